key_debounce: RTL and testbench

- Input conditioner for mechanical keys and switches wired to pulled-up, active-low board pins.
- Sits directly downstream of the pin pull-up network: each raw pin is synchronised to clk, debounced per key, then converted to a clean pressed level plus one-cycle press and release pulses.
- Feeds control FSMs elsewhere in the design.

---
 rtl/key_debounce_if.sv | 11 +
 rtl/key_debounce.sv | 81 ++++++++
 tb/tb_key_debounce.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// key_debounce_if: raw active-low key pins in, debounced level and event pulses out.
interface key_debounce_if #(parameter int KEY_NUM = 4);
    logic [KEY_NUM-1:0] key_in_n;
    logic [KEY_NUM-1:0] key_state;
    logic [KEY_NUM-1:0] key_press;
    logic [KEY_NUM-1:0] key_release;
    logic [KEY_NUM-1:0] key_long;

    modport master (output key_in_n, input key_state, key_press, key_release, key_long);
    modport slave  (input key_in_n, output key_state, key_press, key_release, key_long);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: per-key synchroniser, debouncer and press/release pulse generator.
// Define KEY_LONG_PRESS_EN to add a one-shot long-press pulse per key.
module key_debounce #(
    parameter int KEY_NUM  = 4,
    parameter int DEB_CNT  = 500000,
    parameter int LONG_CNT = 50000000
) (
    input  logic         clk,
    input  logic         rst_n,
    key_debounce_if.slave bus
);
    localparam int CW = $clog2(DEB_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT - 1);

    logic [KEY_NUM-1:0] r_sync1, r_sync2, r_state, r_press, r_release;
    logic [CW-1:0]      r_cnt [KEY_NUM];
    logic [KEY_NUM-1:0] w_level;

    // Pins idle high through the pull-up, so the synchroniser resets to 1.
    assign w_level = ~r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '1;
            r_sync2   <= '1;
            r_state   <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < KEY_NUM; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1   <= bus.key_in_n;
            r_sync2   <= r_sync1;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < KEY_NUM; i++) begin
                if (w_level[i] == r_state[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_cnt[i]     <= '0;
                    r_state[i]   <= w_level[i];
                    r_press[i]   <= w_level[i];
                    r_release[i] <= r_state[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.key_state   = r_state;
    assign bus.key_press   = r_press;
    assign bus.key_release = r_release;

`ifdef KEY_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CNT + 1);
    localparam logic [LW-1:0] HOLD_FIRE = LW'(LONG_CNT - 1);
    localparam logic [LW-1:0] HOLD_MAX  = LW'(LONG_CNT);

    logic [LW-1:0]      r_hold [KEY_NUM];
    logic [KEY_NUM-1:0] r_long;

    // Parking the count at LONG_CNT keeps it to one pulse per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_long <= '0;
            for (int i = 0; i < KEY_NUM; i++) r_hold[i] <= '0;
        end else begin
            for (int i = 0; i < KEY_NUM; i++) begin
                r_long[i] <= r_state[i] && (r_hold[i] == HOLD_FIRE);
                r_hold[i] <= !r_state[i] ? '0 :
                             (r_hold[i] == HOLD_FIRE || r_hold[i] == HOLD_MAX) ? HOLD_MAX :
                             r_hold[i] + 1'b1;
            end
        end
    end

    assign bus.key_long = r_long;
`else
    assign bus.key_long = '0;
`endif
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed checks of reset, press/release timing, bounce and glitch rejection, long press.
module tb_key_debounce;
    localparam int KN = 2;
    localparam int DC = 4;
    localparam int LC = 10;
`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int pass_cnt = 0;
    int total_cnt = 0;

    key_debounce_if #(.KEY_NUM(KN)) bus ();

    key_debounce #(.KEY_NUM(KN), .DEB_CNT(DC), .LONG_CNT(LC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        bus.key_in_n = 2'b00;
        rst_n = 1'b0;
        step(3);
        total_cnt++;
        if (bus.key_state !== 2'b00) $display("FAIL reset_state: got %b want 00", bus.key_state); else pass_cnt++;
        total_cnt++;
        if ({bus.key_press, bus.key_release} !== 4'b0000) $display("FAIL reset_pulses: got %b want 0000", {bus.key_press, bus.key_release}); else pass_cnt++;
        total_cnt++;
        if (bus.key_long !== 2'b00) $display("FAIL reset_long: got %b want 00", bus.key_long); else pass_cnt++;
        rst_n = 1'b1;
        step(5);
        total_cnt++;
        if (bus.key_state !== 2'b00) $display("FAIL reset_early: got %b want 00", bus.key_state); else pass_cnt++;
        step(1);
        total_cnt++;
        if (bus.key_state !== 2'b11) $display("FAIL reset_held_state: got %b want 11", bus.key_state); else pass_cnt++;
        total_cnt++;
        if (bus.key_press !== 2'b11) $display("FAIL reset_held_press: got %b want 11", bus.key_press); else pass_cnt++;
        step(1);
        total_cnt++;
        if (bus.key_press !== 2'b00) $display("FAIL reset_press_width: got %b want 00", bus.key_press); else pass_cnt++;
    endtask

    task automatic test_release_both;
        bus.key_in_n = 2'b11;
        step(5);
        total_cnt++;
        if (bus.key_state !== 2'b11) $display("FAIL rel_both_early: got %b want 11", bus.key_state); else pass_cnt++;
        step(1);
        total_cnt++;
        if (bus.key_release !== 2'b11) $display("FAIL rel_both_pulse: got %b want 11", bus.key_release); else pass_cnt++;
        total_cnt++;
        if ({bus.key_state, bus.key_press} !== 4'b0000) $display("FAIL rel_both_state: got %b want 0000", {bus.key_state, bus.key_press}); else pass_cnt++;
        step(1);
        total_cnt++;
        if (bus.key_release !== 2'b00) $display("FAIL rel_both_width: got %b want 00", bus.key_release); else pass_cnt++;
    endtask

    task automatic test_clean_press;
        bus.key_in_n = 2'b10;
        step(5);
        total_cnt++;
        if (bus.key_state !== 2'b00) $display("FAIL press_early: got %b want 00", bus.key_state); else pass_cnt++;
        step(1);
        total_cnt++;
        if (bus.key_state !== 2'b01) $display("FAIL press_state: got %b want 01", bus.key_state); else pass_cnt++;
        total_cnt++;
        if ({bus.key_press, bus.key_release} !== 4'b0100) $display("FAIL press_pulse: got %b want 0100", {bus.key_press, bus.key_release}); else pass_cnt++;
        step(1);
        total_cnt++;
        if ({bus.key_press, bus.key_release} !== 4'b0000) $display("FAIL press_width: got %b want 0000", {bus.key_press, bus.key_release}); else pass_cnt++;
    endtask

    task automatic test_bounce;
        int presses = 0;
        int bad = 0;
        bus.key_in_n = 2'b11;
        step(8);
        for (int j = 0; j < 4; j++) begin
            bus.key_in_n[0] = j[0];
            repeat (2) begin
                step(1);
                if (bus.key_state !== 2'b00 || bus.key_press !== 2'b00) bad++;
            end
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL bounce_quiet: got %0d changes want 0", bad); else pass_cnt++;
        bus.key_in_n[0] = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step(1);
            if (bus.key_press[0]) presses++;
            if (i == 6) begin
                total_cnt++;
                if (bus.key_press !== 2'b01) $display("FAIL bounce_press_time: got %b want 01", bus.key_press); else pass_cnt++;
            end
        end
        total_cnt++;
        if (presses !== 1) $display("FAIL bounce_press_count: got %0d want 1", presses); else pass_cnt++;
    endtask

    task automatic test_glitch;
        int bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (i == 0) bus.key_in_n = 2'b00;
            if (i == 3) bus.key_in_n = 2'b10;
            step(1);
            if (bus.key_state !== 2'b01 || bus.key_press !== 2'b00 || bus.key_release !== 2'b00) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL glitch: got %0d changes want 0", bad); else pass_cnt++;
    endtask

    task automatic test_release_indep;
        bus.key_in_n = 2'b01;
        step(5);
        total_cnt++;
        if (bus.key_state !== 2'b01) $display("FAIL indep_early: got %b want 01", bus.key_state); else pass_cnt++;
        step(1);
        total_cnt++;
        if ({bus.key_press, bus.key_release} !== 4'b1001) $display("FAIL indep_pulses: got %b want 1001", {bus.key_press, bus.key_release}); else pass_cnt++;
        total_cnt++;
        if (bus.key_state !== 2'b10) $display("FAIL indep_state: got %b want 10", bus.key_state); else pass_cnt++;
        step(1);
        total_cnt++;
        if ({bus.key_press, bus.key_release} !== 4'b0000) $display("FAIL indep_width: got %b want 0000", {bus.key_press, bus.key_release}); else pass_cnt++;
    endtask

    task automatic test_long;
        int longs = 0;
        bus.key_in_n = 2'b00;
        step(6);
        total_cnt++;
        if (bus.key_press !== 2'b01) $display("FAIL long_press: got %b want 01", bus.key_press); else pass_cnt++;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (bus.key_long[0]) longs++;
            if (!LONG_EN && bus.key_long !== 2'b00) longs++;
            if (i == LC) begin
                total_cnt++;
                if (bus.key_long[0] !== LONG_EN) $display("FAIL long_time: got %b want %b", bus.key_long[0], LONG_EN); else pass_cnt++;
            end
        end
        total_cnt++;
        if (longs !== (LONG_EN ? 1 : 0)) $display("FAIL long_count: got %0d want %0d", longs, LONG_EN ? 1 : 0); else pass_cnt++;
    endtask

    initial begin
        bus.key_in_n = 2'b00;
        test_reset();
        test_release_both();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release_indep();
        test_long();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
